// File: rtl/fp_mul_pipe_pkg.sv
// Shared widths, operand classes and flag bit positions for the pipelined FP multiplier.
package fp_mul_pkg;

  localparam int EW_DEF = 8;
  localparam int MW_DEF = 23;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INV = 2;
  localparam int NFLAGS   = 3;

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan_bits(input int ew, input int mw);
    logic [63:0] r;
    r = ((64'd1 << ew) - 64'd1) << mw;
    r = r | (64'd1 << (mw - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
interface fp_mul_if import fp_mul_pkg::*; #(
  parameter int P = 1 + EW_DEF + MW_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] a;
  logic [P-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] p;
  logic         ovf;
  logic         unf;
  logic         inv;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, p, ovf, unf, inv);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, p, ovf, unf, inv);
endinterface

// File: rtl/fp_mul_pipe_round.sv
// Stage 3 of the multiplier: normalise the raw mantissa product, round to nearest even, pack.
module fp_mul_round import fp_mul_pkg::*; #(
  parameter int EW = EW_DEF,
  parameter int MW = MW_DEF,
  parameter int P  = 1 + EW + MW
) (
  input  logic [2*MW+1:0]    prod,
  input  logic signed [EW+1:0] esum,
  input  logic               sign,
  input  fp_class_e          cls,
  output logic [P-1:0]       p,
  output logic               ovf,
  output logic               unf,
  output logic               inv
);

  localparam logic signed [EW+1:0] EXP_MAX  = (EW+2)'((2**EW) - 1);
  localparam logic signed [EW+1:0] EXP_ZERO = '0;

  logic                  msb, lost, g, r, s, rnd_up, carry;
  logic [2*MW-1:0]       frac;
  logic [MW:0]           mr;
  logic signed [EW+1:0]  exp_r;

  always_comb begin
    msb    = prod[2*MW+1];
    // frac holds the bits below the hidden one; a bit shifted out on normalise joins sticky
    frac   = msb ? prod[2*MW:1] : prod[2*MW-1:0];
    lost   = msb & prod[0];
    g      = frac[MW-1];
    r      = frac[MW-2];
    s      = (|frac[MW-3:0]) | lost;
    rnd_up = g & (r | s | frac[MW]);
    mr     = {1'b0, frac[2*MW-1:MW]} + (MW+1)'(rnd_up);
    carry  = mr[MW];
    exp_r  = esum + $signed((EW+2)'(msb)) + $signed((EW+2)'(carry));

    p   = '0;
    ovf = 1'b0;
    unf = 1'b0;
    inv = 1'b0;
    case (cls)
      CLS_NAN: begin
        p   = P'(qnan_bits(EW, MW));
        inv = 1'b1;
      end
      CLS_INF:  p = {sign, {EW{1'b1}}, {MW{1'b0}}};
      CLS_ZERO: p = {sign, {(P-1){1'b0}}};
      default: begin
        if (exp_r >= EXP_MAX) begin
          p   = {sign, {EW{1'b1}}, {MW{1'b0}}};
          ovf = 1'b1;
        end else if (exp_r <= EXP_ZERO) begin
          p   = {sign, {(P-1){1'b0}}};
          unf = 1'b1;
        end else begin
          p = {sign, exp_r[EW-1:0], mr[MW-1:0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Stage 1 unpacks/classifies, stage 2 multiplies mantissas, stage 3 rounds and packs.
module fp_mul_pipe import fp_mul_pkg::*; #(
  parameter int EW   = EW_DEF,
  parameter int MW   = MW_DEF,
  parameter int BIAS = 2**(EW-1) - 1,
  parameter int P    = 1 + EW + MW
) (
  input logic  clk,
  input logic  rst,
  fp_mul_if.slave bus
);

  logic                 en;
  logic                 s1_valid, s1_sign;
  fp_class_e            s1_cls;
  logic signed [EW+1:0] s1_esum;
  logic [MW-1:0]        s1_ma, s1_mb;
  logic                 s2_valid, s2_sign;
  fp_class_e            s2_cls;
  logic signed [EW+1:0] s2_esum;
  logic [2*MW+1:0]      s2_prod;
  logic                 out_valid_q;
  logic [P-1:0]         p_q;
  logic [NFLAGS-1:0]    flags_q;

  logic [EW-1:0]        ea, eb;
  logic [MW-1:0]        ma, mb;
  fp_class_e            ca, cb, c_in;
  logic signed [EW+1:0] esum;
  logic [P-1:0]         rnd_p;
  logic                 rnd_ovf, rnd_unf, rnd_inv;

  // Zero exponent covers subnormals too: they are flushed to zero.
  function automatic fp_class_e classify(input logic [EW-1:0] e, input logic [MW-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (e == '1) return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  always_comb begin
    ea = bus.a[P-2:MW];
    eb = bus.b[P-2:MW];
    ma = bus.a[MW-1:0];
    mb = bus.b[MW-1:0];
    ca = classify(ea, ma);
    cb = classify(eb, mb);
    if (ca == CLS_NAN || cb == CLS_NAN ||
        (ca == CLS_ZERO && cb == CLS_INF) || (ca == CLS_INF && cb == CLS_ZERO))
      c_in = CLS_NAN;
    else if (ca == CLS_INF || cb == CLS_INF)
      c_in = CLS_INF;
    else if (ca == CLS_ZERO || cb == CLS_ZERO)
      c_in = CLS_ZERO;
    else
      c_in = CLS_NORM;
    esum = $signed((EW+2)'(ea)) + $signed((EW+2)'(eb)) - $signed((EW+2)'(BIAS));
  end

  assign en           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      flags_q     <= '0;
    end else if (en) begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      p_q         <= s2_valid ? rnd_p : '0;
      flags_q     <= '0;
      if (s2_valid) begin
        flags_q[FLAG_OVF] <= rnd_ovf;
        flags_q[FLAG_UNF] <= rnd_unf;
        flags_q[FLAG_INV] <= rnd_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign <= bus.a[P-1] ^ bus.b[P-1];
      s1_cls  <= c_in;
      s1_esum <= esum;
      s1_ma   <= ma;
      s1_mb   <= mb;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_esum <= s1_esum;
      s2_prod <= (2*MW+2)'({1'b1, s1_ma}) * (2*MW+2)'({1'b1, s1_mb});
    end
  end

  fp_mul_round #(.EW(EW), .MW(MW), .P(P)) u_round (
    .prod (s2_prod),
    .esum (s2_esum),
    .sign (s2_sign),
    .cls  (s2_cls),
    .p    (rnd_p),
    .ovf  (rnd_ovf),
    .unf  (rnd_unf),
    .inv  (rnd_inv)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.ovf       = flags_q[FLAG_OVF];
  assign bus.unf       = flags_q[FLAG_UNF];
  assign bus.inv       = flags_q[FLAG_INV];

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (EW=8, MW=23) against an integer-arithmetic reference model.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst;

  fp_mul_if #(.P(32)) bus();

  fp_mul_pipe #(.EW(8), .MW(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        ovf;
    logic        unf;
    logic        inv;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;
  bit   done     = 0;

  // Exact product of the significands with IEEE round-to-nearest-even done on integers.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t r;
    int ex, ey, e, sh;
    longint unsigned m, q, rem, half;
    logic xn, yn, xi, yi, xz, yz, s;
    r.a = x; r.b = y; r.ovf = 0; r.unf = 0; r.inv = 0;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    s  = x[31] ^ y[31];
    if (xn || yn || (xz && yi) || (xi && yz)) begin
      r.p = 32'h7FC00000; r.inv = 1; return r;
    end
    if (xi || yi) begin r.p = {s, 8'hFF, 23'h0}; return r; end
    if (xz || yz) begin r.p = {s, 31'h0}; return r; end
    m = (64'h800000 | 64'(x[22:0])) * (64'h800000 | 64'(y[22:0]));
    e = ex + ey - 127;
    if (m >= 64'h8000_0000_0000) begin sh = 24; e++; end
    else sh = 23;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == 64'h1000000) begin q = q >> 1; e++; end
    if (e >= 255) begin r.p = {s, 8'hFF, 23'h0}; r.ovf = 1; end
    else if (e <= 0) begin r.p = {s, 31'h0}; r.unf = 1; end
    else r.p = {s, 8'(e), q[22:0]};
    return r;
  endfunction

  function automatic res_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] pe,
                              input logic o, input logic u, input logic i);
    res_t r;
    r.a = x; r.b = y; r.p = pe; r.ovf = o; r.unf = u; r.inv = i;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k < 11)       v[30:23] = 8'($urandom_range(64, 190));
    else if (k == 11) v[30:23] = 8'h00;
    else if (k == 12) v[30:23] = 8'hFF;
    else if (k == 13) begin v[30:23] = 8'($urandom_range(100, 150)); v[15:0] = 16'h0; end
    else if (k == 14) v[22:0] = 23'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic send_e(input res_t e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a = e.a;
    bus.b = e.b;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", n);
    end else begin
      sb.push_back(e);
      accepted++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    send_e(model(x, y));
  endtask

  task automatic check_latency(input string name, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    send(x, y);
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk(name, 32'(n), 32'd3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every output handshake is compared with the oldest outstanding expectation.
  res_t got_e;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got p=%h with empty scoreboard, expected no output", bus.p);
      end else begin
        got_e = sb.pop_front();
        if (bus.p !== got_e.p || bus.ovf !== got_e.ovf || bus.unf !== got_e.unf || bus.inv !== got_e.inv) begin
          errors++;
          $display("FAIL result a=%h b=%h: got p=%h ovf=%b unf=%b inv=%b, expected p=%h ovf=%b unf=%b inv=%b",
                   got_e.a, got_e.b, bus.p, bus.ovf, bus.unf, bus.inv,
                   got_e.p, got_e.ovf, got_e.unf, got_e.inv);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_p", bus.p, 32'h0);
    chk("rst_flags", 32'({bus.ovf, bus.unf, bus.inv}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    check_latency("latency_first", 32'h40000000, 32'h40400000);
    drain();

    send_e(mk(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0));
    send_e(mk(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0));
    send_e(mk(32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0));
    send_e(mk(32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0));
    send(32'h3F800001, 32'h3FFFFFFF);
    send_e(mk(32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1));
    send_e(mk(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1));
    send_e(mk(32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0));
    send_e(mk(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 0));
    send_e(mk(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0));
    drain();

    // Backpressure: six back-to-back operands against a stalled output.
    bus.out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_op(), rand_op());
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_accepted", 32'(accepted), 32'd3);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_p_head", bus.p, sb[0].p);
        @(negedge clk);
        chk("stall_p_hold", bus.p, sb[0].p);
        chk("stall_accepted_hold", 32'(accepted), 32'd3);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with results in flight: everything in the pipe is discarded.
    send(32'h40000000, 32'h40400000);
    send(32'h3FC00000, 32'h40400000);
    send(32'h40800000, 32'h40400000);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_latency("latency_after_rst", 32'h40400000, 32'h40400000);
    drain();

    // Randomised operands with random input gaps and output backpressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(rand_op(), rand_op());
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
